hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL provide parameter: CNT_W, 32, width of the performance counters.
REQ-002 SHALL provide port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port: reset_n_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port: id_opcode_i  input  7  opcode of the instruction in ID.
REQ-005 SHALL provide ports: id_rs1_i, id_rs2_i  input  5  source register indices in ID.
REQ-006 SHALL provide ports: ex_rd_i  input  5; ex_reg_write_i, ex_load_i  input  1  ID/EX destination, write-enable and load flags.
REQ-007 SHALL provide ports: mem_rd_i  input  5; mem_load_i  input  1  EX/MEM destination and load flag.
REQ-008 SHALL provide port: id_redirect_i  input  1  taken branch, JAL or JALR resolved in ID.
REQ-009 SHALL provide ports: pc_write_o, ifid_write_o  output  1  PC and IF/ID register enables.
REQ-010 SHALL provide port: bubble_o  output  1  drives the control unit wb_ff_i input, forcing a nop into ID/EX.
REQ-011 SHALL provide port: ifid_flush_o  output  1  clears IF/ID on the next edge.
REQ-012 SHALL provide ports: stall_cnt_o, flush_cnt_o  output  CNT_W  performance counters.

Function
REQ-013 SHALL decode source use from id_opcode_i: 0110011, 0100011, 1100011 use rs1 and rs2; 0010011, 0000011, 1100111 use rs1 only; all other opcodes, including 1101111 (JAL), use none.
REQ-014 SHALL define a match on rsN as: rsN is used, rsN != 0, and rsN equals the compared rd; x0 never matches.
REQ-015 SHALL define resolve-in-ID instructions as opcodes 1100011 and 1100111.
REQ-016 SHALL compute need, in priority order:
- need = 2: ex_load_i and EX match, and the ID instruction is resolve-in-ID.
- need = 1: ex_load_i and EX match; or resolve-in-ID and ex_reg_write_i and EX match; or resolve-in-ID and mem_load_i and MEM match.
- need = 0: otherwise.
REQ-017 SHALL implement FSM states RUN and STALL, plus a 1-bit remaining-stall counter.
REQ-018 In RUN with need > 0, this cycle SHALL drive pc_write_o=0, ifid_write_o=0, bubble_o=1, ifid_flush_o=0; need = 2 SHALL move to STALL with counter 1; need = 1 SHALL stay in RUN and re-evaluate next cycle.
REQ-019 In STALL, the block SHALL hold the stall outputs regardless of inputs, decrement the counter and return to RUN when it reaches 0 (exactly one STALL cycle).
REQ-020 In RUN with need = 0 and id_redirect_i=1, it SHALL drive ifid_flush_o=1, pc_write_o=1, ifid_write_o=1, bubble_o=0.
REQ-021 In RUN with need = 0 and id_redirect_i=0, it SHALL drive pc_write_o=1, ifid_write_o=1, bubble_o=0, ifid_flush_o=0.
REQ-022 When a stall and a redirect occur in the same cycle, the stall SHALL win and id_redirect_i SHALL be ignored, since the operands are not yet valid.
REQ-023 All outputs SHALL be combinational from state and the current inputs; detection SHALL add zero cycles of latency.

Reset
REQ-024 While reset_n_i=0, the block SHALL asynchronously force state to RUN, the stall counter to 0, pc_write_o=0, ifid_write_o=0, bubble_o=1, ifid_flush_o=1, stall_cnt_o=0 and flush_cnt_o=0.
REQ-025 A reset asserted mid-STALL SHALL abandon the stall; the first cycle after release SHALL be evaluated in RUN.

Configuration
REQ-026 With HAZARD_PERF_CNT_EN defined, the counters SHALL behave as follows:
- stall_cnt_o increments each cycle bubble_o=1 out of reset.
- flush_cnt_o increments each cycle ifid_flush_o=1 out of reset.
- Both counters saturate at all-ones.
REQ-027 Without HAZARD_PERF_CNT_EN, stall_cnt_o and flush_cnt_o SHALL remain present and be tied to 0, with no counter flops.

Verification
REQ-028 Load-use: EX = load, ex_rd=5; ID = R-type with rs2=5 -> one cycle of bubble_o=1, pc_write_o=0; next cycle normal.
REQ-029 Load feeding branch: EX = load, ex_rd=7; ID = 1100011 with rs1=7 -> exactly two stall cycles (RUN then STALL), then RUN with outputs normal.
REQ-030 x0 and JAL: ex_load_i=1, ex_rd=0 with ID rs1=0; then ID opcode 1101111 with any rs fields -> no stall in either case.
REQ-031 Redirect versus stall: ID = JALR, rs1=3, ex_reg_write_i=1, ex_rd=3, id_redirect_i=1 -> stall, ifid_flush_o=0; next cycle (no match) -> ifid_flush_o=1.
REQ-032 Reset mid-STALL: assert reset_n_i=0 during the STALL cycle -> outputs take reset values immediately; after release, state is RUN and, with the macro defined, both counters read 0.
REQ-033 Counters: with the macro defined, 3 stalls and 2 flushes -> stall_cnt_o=3, flush_cnt_o=2; preloaded at all-ones plus one more stall -> value holds at all-ones.

Source files
------------

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use / branch-operand stall and redirect flush control
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [6:0]       id_opcode_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_load_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_load_i,
  input  logic             id_redirect_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             bubble_o,
  output logic             ifid_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state_q, state_d;
  logic       rem_q, rem_d;
  logic       use_rs1, use_rs2, resolve_id;
  logic       ex_match, mem_match;
  logic [1:0] need;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_opcode_i)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign resolve_id = (id_opcode_i == 7'b1100011) || (id_opcode_i == 7'b1100111);

  // x0 is hardwired zero, so it never creates a dependency
  assign ex_match  = (use_rs1 && (id_rs1_i != 5'd0) && (id_rs1_i == ex_rd_i)) ||
                     (use_rs2 && (id_rs2_i != 5'd0) && (id_rs2_i == ex_rd_i));
  assign mem_match = (use_rs1 && (id_rs1_i != 5'd0) && (id_rs1_i == mem_rd_i)) ||
                     (use_rs2 && (id_rs2_i != 5'd0) && (id_rs2_i == mem_rd_i));

  always_comb begin
    need = 2'd0;
    if (ex_load_i && ex_match && resolve_id)
      need = 2'd2;
    else if ((ex_load_i && ex_match) ||
             (resolve_id && ex_reg_write_i && ex_match) ||
             (resolve_id && mem_load_i && mem_match))
      need = 2'd1;
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    bubble_o     = 1'b0;
    ifid_flush_o = 1'b0;
    if (!reset_n_i) begin
      state_d      = RUN;
      rem_d        = 1'b0;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      bubble_o     = 1'b1;
      ifid_flush_o = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (need != 2'd0) begin
            // operands not ready yet, so any redirect is not trustworthy
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            bubble_o     = 1'b1;
            if (need == 2'd2) begin
              state_d = STALL;
              rem_d   = 1'b1;
            end
          end else if (id_redirect_i) begin
            ifid_flush_o = 1'b1;
          end
        end
        STALL: begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          bubble_o     = 1'b1;
          rem_d        = rem_q - 1'b1;
          if (rem_d == 1'b0) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RUN;
      rem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // saturating event counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bubble_o && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ifid_flush_o && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        ex_reg_write, ex_load, mem_load, id_redirect;
  logic        pc_write, ifid_write, bubble, ifid_flush;
  logic        s_pc_write, s_ifid_write, s_bubble, s_ifid_flush;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [3:0] O_NORM  = 4'b1100;
  localparam logic [3:0] O_STALL = 4'b0010;
  localparam logic [3:0] O_FLUSH = 4'b1101;
  localparam logic [3:0] O_RST   = 4'b0011;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk_i(clk), .reset_n_i(reset_n), .id_opcode_i(id_opcode),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .ex_rd_i(ex_rd),
    .ex_reg_write_i(ex_reg_write), .ex_load_i(ex_load),
    .mem_rd_i(mem_rd), .mem_load_i(mem_load), .id_redirect_i(id_redirect),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .bubble_o(bubble),
    .ifid_flush_o(ifid_flush), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  hazard_unit #(.CNT_W(2)) dut_small (
    .clk_i(clk), .reset_n_i(reset_n), .id_opcode_i(id_opcode),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .ex_rd_i(ex_rd),
    .ex_reg_write_i(ex_reg_write), .ex_load_i(ex_load),
    .mem_rd_i(mem_rd), .mem_load_i(mem_load), .id_redirect_i(id_redirect),
    .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .bubble_o(s_bubble),
    .ifid_flush_o(s_ifid_flush), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_opcode = 7'b0000000; id_rs1 = 5'd0; id_rs2 = 5'd0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_load = 1'b0;
    mem_rd = 5'd0; mem_load = 1'b0; id_redirect = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [3:0] exp);
    #1;
    check(tag, {28'd0, pc_write, ifid_write, bubble, ifid_flush}, {28'd0, exp});
  endtask

  task automatic cnts(input string tag, input logic [31:0] s_exp, input logic [31:0] f_exp);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall"}, stall_cnt, s_exp);
    check({tag, "_flush"}, flush_cnt, f_exp);
`else
    check({tag, "_stall"}, stall_cnt, 32'd0);
    check({tag, "_flush"}, flush_cnt, 32'd0);
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    tick();
    outs("reset_outs", O_RST);
    cnts("reset_cnt", 0, 0);
    #2 reset_n = 1'b1;
    outs("run_idle", O_NORM);
    tick();

    // load-use on rs2
    ex_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
    id_opcode = 7'b0110011; id_rs1 = 5'd1; id_rs2 = 5'd5;
    outs("load_use_stall", O_STALL);
    tick();
    idle(); id_opcode = 7'b0110011; id_rs2 = 5'd5; mem_load = 1'b1; mem_rd = 5'd5;
    outs("load_use_after", O_NORM);
    tick();

    // load feeding a branch: RUN stall, then one STALL cycle
    idle(); ex_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7;
    id_opcode = 7'b1100011; id_rs1 = 5'd7;
    outs("ld_br_run", O_STALL);
    tick();
    idle();
    outs("ld_br_stall", O_STALL);
    tick();
    outs("ld_br_done", O_NORM);
    tick();

    // x0, JAL and an unused rs2 never stall
    ex_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0;
    id_opcode = 7'b0010011; id_rs1 = 5'd0;
    outs("x0_nostall", O_NORM);
    tick();
    ex_rd = 5'd5; id_opcode = 7'b1101111; id_rs1 = 5'd5; id_rs2 = 5'd5;
    outs("jal_nostall", O_NORM);
    tick();
    id_opcode = 7'b0010011; id_rs1 = 5'd1; id_rs2 = 5'd5;
    outs("itype_rs2_unused", O_NORM);
    tick();

    // stall beats redirect, then the redirect flushes
    idle(); id_opcode = 7'b1100111; id_rs1 = 5'd3;
    ex_reg_write = 1'b1; ex_rd = 5'd3; id_redirect = 1'b1;
    outs("redir_vs_stall", O_STALL);
    tick();
    ex_rd = 5'd4;
    outs("redir_flush", O_FLUSH);
    tick();

    // branch on a value still loading in MEM
    idle(); id_opcode = 7'b1100011; id_rs2 = 5'd9; mem_load = 1'b1; mem_rd = 5'd9;
    outs("mem_load_br", O_STALL);
    tick();
    // non-resolve instruction ignores a MEM load match
    id_opcode = 7'b0110011;
    outs("mem_load_alu", O_NORM);
    tick();
    idle(); id_redirect = 1'b1;
    outs("redir_plain", O_FLUSH);
    tick();
    idle();
    #1;
    cnts("cnt_totals", 5, 2);
`ifdef HAZARD_PERF_CNT_EN
    check("sat_stall", {30'd0, s_stall_cnt}, 32'd3);
    check("small_flush", {30'd0, s_flush_cnt}, 32'd2);
`else
    check("sat_stall", {30'd0, s_stall_cnt}, 32'd0);
    check("small_flush", {30'd0, s_flush_cnt}, 32'd0);
`endif
    tick();

    // reset during STALL abandons it
    ex_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7;
    id_opcode = 7'b1100011; id_rs1 = 5'd7;
    outs("rst_pre_run", O_STALL);
    tick();
    idle();
    outs("rst_pre_stall", O_STALL);
    #1 reset_n = 1'b0;
    outs("rst_mid_stall", O_RST);
    cnts("rst_mid_cnt", 0, 0);
    tick();
    #1 reset_n = 1'b1;
    outs("rst_after_run", O_NORM);
    cnts("rst_after_cnt", 0, 0);
    tick();
    outs("rst_after_run2", O_NORM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
